ps2_kbd_rx: RTL and testbench

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

---
 rtl/ps2_kbd_rx.sv | 199 +++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with clock filter, frame FSM and output buffer
//
// Parameters
//   FILTER_LEN      cycles ps2_clk must be stable before the filtered clock follows it
//   TIMEOUT_CYCLES  max clk25 cycles between filtered falling edges inside a frame
// Ports
//   clk25       system clock (25 MHz)
//   rst_n       asynchronous active-low reset
//   ps2_clk     PS/2 clock from keyboard (asynchronous)
//   ps2_din     PS/2 data from keyboard (asynchronous)
//   rx_data     byte at the head of the receive buffer
//   rx_valid    rx_data holds an unread byte
//   rx_ready    consumer takes rx_data when rx_valid & rx_ready
//   parity_err  one-cycle pulse: frame dropped for bad parity
//   frame_err   one-cycle pulse: bad start/stop bit or inter-edge timeout
//   overflow    sticky: good byte dropped because the buffer was full
//   busy        a frame is in progress
// Build option
//   PS2_RX_FIFO_EN  defined: 4-entry FIFO; undefined: single holding register
`timescale 1ns/1ps
module ps2_kbd_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_din,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, din_sync;
    logic          clk_filt, clk_filt_d;
    logic [FW-1:0] filt_cnt;
    logic          fall, din_bit;

    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          par_bit, par_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          timeout;
    logic          push, push_n, pe_n, fe_n;
    logic          pop, accept;

    // Line idles high, so synchronizers and filter come out of reset at 1
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync   <= 2'b11;
            din_sync   <= 2'b11;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            din_sync   <= {din_sync[0], ps2_din};
            clk_filt_d <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall    = clk_filt_d & ~clk_filt;
    assign din_bit = din_sync[1];
    assign busy    = (state != IDLE);
    assign timeout = busy && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            push       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            par_bit    <= par_n;
            to_cnt     <= to_cnt_n;
            push       <= push_n;
            parity_err <= pe_n;
            frame_err  <= fe_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        par_n     = par_bit;
        to_cnt_n  = (!busy || fall) ? '0 : to_cnt + 1'b1;
        push_n    = 1'b0;
        pe_n      = 1'b0;
        fe_n      = 1'b0;
        if (timeout) begin
            fe_n    = 1'b1;
            state_n = IDLE;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    state_n   = din_bit ? IDLE : DATA;
                    bit_cnt_n = '0;
                    fe_n      = din_bit;
                end
                DATA: begin
                    shift_n   = {din_bit, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    state_n   = (bit_cnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = din_bit;
                    state_n = STOP;
                end
                default: begin
                    // A bad stop bit masks any parity verdict
                    state_n = IDLE;
                    fe_n    = ~din_bit;
                    push_n  = din_bit & ^{shift, par_bit};
                    pe_n    = din_bit & ~^{shift, par_bit};
                end
            endcase
        end
    end

    assign pop = rx_valid & rx_ready;

`ifdef PS2_RX_FIFO_EN
    logic [7:0] mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;

    // A simultaneous pop frees the slot the push lands in, so full is no obstacle then
    assign accept   = push & (~count[2] | pop);
    assign rx_data  = mem[rd_ptr];
    assign rx_valid = |count;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b0, accept} - {2'b0, pop};
            if (push && !accept) overflow <= 1'b1;
        end
    end
`else
    logic [7:0] data_q;
    logic       valid_q;

    assign accept   = push & (~valid_q | pop);
    assign rx_data  = data_q;
    assign rx_valid = valid_q;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                data_q  <= shift;
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
            if (push && !accept) overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: randomized scoreboard bench for ps2_kbd_rx
`timescale 1ns/1ps
module tb_ps2_kbd_rx;
    logic       clk25 = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_din = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, overflow, busy;

`ifdef PS2_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    int         checks = 0;
    int         passes = 0;
    logic [7:0] exp_q[$];
    int         pe_seen = 0, fe_seen = 0, pe_exp = 0, fe_exp = 0, busy_seen = 0;
    logic       exp_ovf = 1'b0;
    logic       rnd_ready = 1'b0;
    logic       ready_force = 1'b1;

    ps2_kbd_rx dut (
        .clk25(clk25), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_din(ps2_din),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow), .busy(busy)
    );

    always #20 clk25 = ~clk25;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk25);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            ps2_din = bits[i];
            wait_cyc(half);
            ps2_clk = 1'b0;
            wait_cyc(half);
            ps2_clk = 1'b1;
        end
        ps2_din = 1'b1;
    endtask

    // Reference model: a frame is a byte iff stop is 1 and data+parity has odd weight;
    // a bad stop bit is a framing error regardless of parity
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop, input int half);
        logic par;
        par = ~^d ^ bad_par;
        if (!stop) fe_exp++;
        else if (bad_par) pe_exp++;
        else if (!rnd_ready && !ready_force && exp_q.size() >= CAP) exp_ovf = 1'b1;
        else exp_q.push_back(d);
        send_bits({stop, par, d, 1'b0}, 11, half);
        wait_cyc(half);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk25);
            n++;
        end
        @(negedge clk25);
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial forever begin
        @(posedge clk25);
        #1;
        rx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    always @(negedge clk25) begin
        if (rst_n) begin
            if (parity_err) pe_seen++;
            if (frame_err) fe_seen++;
            if (busy) busy_seen++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_byte: got 0x%0h required none", rx_data);
                end else begin
                    chk("rx_data", rx_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #(40 * 95000);
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         kind;
        wait_cyc(4);
        @(negedge clk25);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        wait_cyc(5);

        send_frame(8'h1C, 1'b0, 1'b1, 1000);
        drain();
        chk("slow_pe", pe_seen, pe_exp);
        chk("slow_fe", fe_seen, fe_exp);

        send_frame(8'h1C, 1'b1, 1'b1, 50);
        wait_cyc(50);
        @(negedge clk25);
        chk("badpar_pe", pe_seen, pe_exp);
        chk("badpar_valid", rx_valid, 0);

        busy_seen = 0;
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(40);
        @(negedge clk25);
        chk("glitch_busy", busy_seen, 0);
        chk("glitch_fe", fe_seen, fe_exp);

        fe_exp++;
        send_bits({7'h00, 4'($urandom), 1'b0} & 11'h01E, 5, 40);
        wait_cyc(30000);
        @(negedge clk25);
        chk("timeout_fe", fe_seen, fe_exp);
        chk("timeout_busy", busy, 0);
        send_frame(8'h5A, 1'b0, 1'b1, 40);
        drain();
        chk("after_timeout_fe", fe_seen, fe_exp);

        rnd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            kind = $urandom_range(0, 5);
            send_frame(d, kind == 0 || (kind == 1 && d[0]), kind != 1, $urandom_range(15, 60));
        end
        drain();
        chk("rand_pe", pe_seen, pe_exp);
        chk("rand_fe", fe_seen, fe_exp);
        rnd_ready = 1'b0;
        ready_force = 1'b1;

        send_bits(11'h014, 5, 30);
        @(negedge clk25);
        rst_n = 1'b0;
        wait_cyc(2);
        @(negedge clk25);
        rst_n = 1'b1;
        send_frame(8'h66, 1'b0, 1'b1, 30);
        drain();
        chk("midrst_pe", pe_seen, pe_exp);
        chk("midrst_fe", fe_seen, fe_exp);

        ready_force = 1'b0;
        wait_cyc(2);
        @(negedge clk25);
        chk("pre_ovf", overflow, 0);
        send_frame(8'hF0, 1'b0, 1'b1, 30);
        send_frame(8'h1C, 1'b0, 1'b1, 30);
        send_frame(8'h12, 1'b0, 1'b1, 30);
        send_frame(8'h29, 1'b0, 1'b1, 30);
        send_frame(8'h5A, 1'b0, 1'b1, 30);
        wait_cyc(30);
        @(negedge clk25);
        chk("ovf_set", overflow, exp_ovf);
        chk("ovf_valid", rx_valid, 1);
        chk("ovf_head", rx_data, 8'hF0);
        chk("ovf_held", exp_q.size(), CAP);
        ready_force = 1'b1;
        drain();
        chk("ovf_sticky", overflow, 1);
        chk("ovf_empty", rx_valid, 0);
        chk("final_pe", pe_seen, pe_exp);
        chk("final_fe", fe_seen, fe_exp);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
